// File: rtl/hilo_pkg.sv
// Shared constants for the Hi/Lo sequencing controller: opcodes, FSM states, default engine latencies.
package hilo_pkg;
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_MTHI = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4;

  localparam int DIV_LAT_DEF  = 32;
  localparam int MULT_LAT_DEF = 33;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_CAPTURE
  } state_t;
endpackage

// File: rtl/hilo_ctrl_if.sv
// Request, result and engine-side signals of the Hi/Lo controller.
interface hilo_ctrl_if;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_zero_exc;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] eng_a;
  logic [31:0] eng_b;
  logic        eng_div_start;
  logic        eng_mult_start;
  logic        eng_clr;
  logic [31:0] div_hi_in;
  logic [31:0] div_lo_in;
  logic [31:0] mult_hi_in;
  logic [31:0] mult_lo_in;

  // CPU control unit plus the two engines
  modport master (
    output op_valid, op_code, op_a, op_b, flush,
    output div_hi_in, div_lo_in, mult_hi_in, mult_lo_in,
    input  busy, done, div_zero_exc, hi, lo,
    input  eng_a, eng_b, eng_div_start, eng_mult_start, eng_clr
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, flush,
    input  div_hi_in, div_lo_in, mult_hi_in, mult_lo_in,
    output busy, done, div_zero_exc, hi, lo,
    output eng_a, eng_b, eng_div_start, eng_mult_start, eng_clr
  );
endinterface

// File: rtl/hilo_ctrl.sv
// Launches the divider/multiplier, counts their fixed latency and captures results into Hi/Lo.
// busy spans LAT+2 cycles; op_valid is ignored while busy; flush aborts and clears the engines.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int CNT_W    = 6
) (
  input  logic       clk,
  input  logic       reset,
  hilo_ctrl_if.slave bus
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              op_is_div;
  logic [31:0]       hi_q, lo_q, eng_a_q, eng_b_q;
  logic              done_q, dz_q, clr_q;
  logic              eng_req;

  always_comb begin
    eng_req   = 1'b0;
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        eng_req = bus.op_valid &&
                  ((bus.op_code == OP_MULT) || ((bus.op_code == OP_DIV) && (bus.op_b != '0)));
        if (eng_req) state_nxt = ST_START;
      end
      ST_START:   state_nxt = ST_WAIT;
      ST_WAIT:    if (cnt == CNT_W'(1)) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (bus.flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      op_is_div <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      eng_a_q   <= '0;
      eng_b_q   <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      clr_q  <= 1'b0;
      if (bus.flush) begin
        clr_q <= (state != ST_IDLE);
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.op_valid) begin
              case (bus.op_code)
                OP_MULT, OP_DIV: begin
                  // a zero divisor never reaches the engine; it only raises the exception
                  if ((bus.op_code == OP_DIV) && (bus.op_b == '0)) begin
                    dz_q <= 1'b1;
                  end else begin
                    eng_a_q   <= bus.op_a;
                    eng_b_q   <= bus.op_b;
                    op_is_div <= (bus.op_code == OP_DIV);
                  end
                end
                OP_MTHI: begin
                  hi_q   <= bus.op_a;
                  done_q <= 1'b1;
                end
                OP_MTLO: begin
                  lo_q   <= bus.op_a;
                  done_q <= 1'b1;
                end
                OP_NOP:  ;
                default: ;
              endcase
            end
          end
          ST_START: cnt <= op_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
          ST_WAIT:  cnt <= cnt - 1'b1;
          ST_CAPTURE: begin
            hi_q   <= op_is_div ? bus.div_hi_in : bus.mult_hi_in;
            lo_q   <= op_is_div ? bus.div_lo_in : bus.mult_lo_in;
            done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy           = (state != ST_IDLE);
  assign bus.eng_div_start  = (state == ST_START) &&  op_is_div;
  assign bus.eng_mult_start = (state == ST_START) && !op_is_div;
  assign bus.done           = done_q;
  assign bus.div_zero_exc   = dz_q;
  assign bus.eng_clr        = clr_q;
  assign bus.hi             = hi_q;
  assign bus.lo             = lo_q;
  assign bus.eng_a          = eng_a_q;
  assign bus.eng_b          = eng_b_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: behavioural divider/multiplier models plus a Hi/Lo scoreboard checked on done.
module tb_hilo_ctrl;
  import hilo_pkg::*;

  localparam int DIV_LAT  = 32;
  localparam int MULT_LAT = 33;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hilo_ctrl_if bus ();

  hilo_ctrl #(.DIV_LAT(DIV_LAT), .MULT_LAT(MULT_LAT), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb[$];
  logic [31:0] cur_hi = '0, cur_lo = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine models: results become valid LAT edges after the edge that samples start; garbage before.
  logic [31:0] div_hi_r = '0, div_lo_r = '0, mult_hi_r = '0, mult_lo_r = '0;
  logic [63:0] div_res, mult_res;
  int dcnt = 0, mcnt = 0;
  assign bus.div_hi_in  = div_hi_r;
  assign bus.div_lo_in  = div_lo_r;
  assign bus.mult_hi_in = mult_hi_r;
  assign bus.mult_lo_in = mult_lo_r;

  always @(posedge clk) begin
    if (bus.eng_clr) begin
      dcnt <= 0;
      mcnt <= 0;
    end else begin
      if (bus.eng_div_start) begin
        dcnt     <= DIV_LAT;
        div_hi_r <= 32'hBAD0BAD0;
        div_lo_r <= 32'hBAD0BAD0;
        if (bus.eng_b != 0)
          div_res <= {32'($signed(bus.eng_a) % $signed(bus.eng_b)),
                      32'($signed(bus.eng_a) / $signed(bus.eng_b))};
      end else if (dcnt != 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) {div_hi_r, div_lo_r} <= div_res;
      end
      if (bus.eng_mult_start) begin
        mcnt      <= MULT_LAT;
        mult_hi_r <= 32'hBAD1BAD1;
        mult_lo_r <= 32'hBAD1BAD1;
        mult_res  <= 64'($signed(bus.eng_a) * $signed(bus.eng_b));
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) {mult_hi_r, mult_lo_r} <= mult_res;
      end
    end
  end

  // Scoreboard: every done must match the oldest pending Hi/Lo expectation.
  always @(negedge clk) begin
    if (reset && bus.done) begin
      if (sb.size() == 0) begin
        check_eq("done_unexpected", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check_eq("sb_hi", {32'd0, bus.hi}, {32'd0, e[63:32]});
        check_eq("sb_lo", {32'd0, bus.lo}, {32'd0, e[31:0]});
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl);
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.flush    = fl;
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic run_eng(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_busy,
                         input logic [31:0] eh, input logic [31:0] el);
    int n = 0, starts = 0, unstable = 0;
    sb.push_back({eh, el});
    issue(op, a, b, 1'b0);
    check_eq({tag, "_start"}, 64'(op == OP_DIV ? bus.eng_div_start : bus.eng_mult_start), 64'd1);
    while (bus.busy && n < 200) begin
      n++;
      if (bus.eng_div_start || bus.eng_mult_start) starts++;
      if (bus.eng_a !== a || bus.eng_b !== b) unstable++;
      @(negedge clk);
    end
    check_eq({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    check_eq({tag, "_start_pulses"}, 64'(starts), 64'd1);
    check_eq({tag, "_eng_ab_stable"}, 64'(unstable), 64'd0);
    check_eq({tag, "_done"}, 64'(bus.done), 64'd1);
    cur_hi = eh;
    cur_lo = el;
  endtask

  initial begin
    bus.op_valid = 1'b0;
    bus.op_code  = OP_NOP;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.flush    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check_eq("rst_eng_ab", {bus.eng_a, bus.eng_b}, 64'd0);
    check_eq("rst_pulses", {60'd0, bus.done, bus.div_zero_exc, bus.eng_clr,
                            bus.eng_div_start | bus.eng_mult_start}, 64'd0);

    run_eng("div100_7", OP_DIV, 32'd100, 32'd7, DIV_LAT + 2, 32'd2, 32'd14);
    // issued in the done cycle: back-to-back acceptance
    run_eng("mult", OP_MULT, 32'h0001_0000, 32'h0001_0000, MULT_LAT + 2, 32'h1, 32'h0);
    run_eng("div_neg", OP_DIV, -32'sd100, 32'd7, DIV_LAT + 2, -32'sd2, -32'sd14);

    issue(OP_DIV, 32'd5, 32'd0, 1'b0);
    check_eq("dz_exc", 64'(bus.div_zero_exc), 64'd1);
    check_eq("dz_busy", 64'(bus.busy), 64'd0);
    check_eq("dz_no_start", 64'(bus.eng_div_start), 64'd0);
    check_eq("dz_no_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    check_eq("dz_exc_one_cycle", 64'(bus.div_zero_exc), 64'd0);
    check_eq("dz_hilo_kept", {bus.hi, bus.lo}, {cur_hi, cur_lo});

    sb.push_back({32'hDEADBEEF, cur_lo});
    issue(OP_MTHI, 32'hDEADBEEF, 32'd0, 1'b0);
    check_eq("mthi_busy", 64'(bus.busy), 64'd0);
    cur_hi = 32'hDEADBEEF;
    sb.push_back({cur_hi, 32'h12345678});
    issue(OP_MTLO, 32'h12345678, 32'd0, 1'b0);
    check_eq("mtlo_done", 64'(bus.done), 64'd1);
    cur_lo = 32'h12345678;
    @(negedge clk);

    issue(3'd7, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check_eq("illegal_ignored", {62'd0, bus.busy, bus.done}, 64'd0);

    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (11) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check_eq("flush_clr", 64'(bus.eng_clr), 64'd1);
    check_eq("flush_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check_eq("flush_clr_one_cycle", 64'(bus.eng_clr), 64'd0);
    repeat (45) @(negedge clk);
    check_eq("flush_hilo_kept", {bus.hi, bus.lo}, {cur_hi, cur_lo});
    run_eng("div9_2", OP_DIV, 32'd9, 32'd2, DIV_LAT + 2, 32'd1, 32'd4);

    issue(OP_MTHI, 32'h1111_1111, 32'd0, 1'b1);
    check_eq("flush_idle_drop", {62'd0, bus.done, bus.eng_clr}, 64'd0);
    check_eq("flush_idle_hi", {32'd0, bus.hi}, {32'd0, cur_hi});

    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_busy", 64'(bus.busy), 64'd0);
    check_eq("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    check_eq("arst_eng_ab", {bus.eng_a, bus.eng_b}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    check_eq("arst_after_hilo", {bus.hi, bus.lo}, 64'd0);
    check_eq("arst_after_busy", 64'(bus.busy), 64'd0);

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
Sequencing controller for the iterative signed divider and the multi-cycle multiplier. It sits between the main CPU control unit and both engines. It accepts MULT/DIV/MTHI/MTLO requests and launches the selected engine with a one-cycle start pulse. The engines have no done flag, so the block counts the engine latency itself, then captures results into the architectural Hi/Lo registers. It stalls the CPU via busy and raises divide-by-zero before any engine is started.

Parameters:
DIV_LAT, 32, cycles from the edge sampling eng_div_start to the divider's Hi/Lo being valid.
MULT_LAT, 33, cycles from the edge sampling eng_mult_start to the multiplier's Hi/Lo being valid.
CNT_W, 6, width of the latency counter; must hold max(DIV_LAT, MULT_LAT).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset.
op_valid  in  1  request strobe from control unit; sampled only when busy=0.
op_code  in  3  0 NOP, 1 MULT, 2 DIV, 3 MTHI, 4 MTLO; 5-7 treated as NOP.
op_a  in  32  operand A (dividend/multiplicand/MTxx source).
op_b  in  32  operand B (divisor/multiplier).
flush  in  1  abort any in-flight operation.
busy  out  1  high while an operation is in flight; the CPU holds the issuing instruction.
done  out  1  one-cycle pulse, coincident with the cycle Hi/Lo first show new values.
div_zero_exc  out  1  one-cycle pulse on a DIV with op_b==0.
hi  out  32  architectural Hi.
lo  out  32  architectural Lo.
eng_a  out  32  latched operand A to engines; stable from accept to return to IDLE.
eng_b  out  32  latched operand B to engines; same stability rule.
eng_div_start  out  1  one-cycle start pulse to the divider.
eng_mult_start  out  1  one-cycle start pulse to the multiplier.
eng_clr  out  1  one-cycle active-high synchronous clear to both engines on flush.
div_hi_in, div_lo_in  in  32 each  divider results.
mult_hi_in, mult_lo_in  in  32 each  multiplier results.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, counter=0.
  - hi, lo, eng_a, eng_b = 0.
  - busy, done, div_zero_exc, eng_*_start, eng_clr = 0.
  - Reset mid-operation discards the operation with no capture.
- States: IDLE, START, WAIT, CAPTURE.
- IDLE, op_valid=1, accept edge e0:
  - MULT/DIV with nonzero divisor: latch op_a/op_b to eng_a/eng_b, record the op, go to START, busy=1.
  - DIV with op_b==0: no engine start, hi/lo unchanged, div_zero_exc=1 for the next cycle only, done=0, busy stays 0.
  - MTHI: hi<=op_a at e0, done=1 the next cycle, busy stays 0. MTLO: same for lo.
  - NOP or illegal code: ignored.
- START: assert the selected eng_*_start for exactly this cycle. At the end edge, load counter with DIV_LAT or MULT_LAT; go to WAIT.
- WAIT: decrement the counter each cycle; when the counter reads 1, go to CAPTURE.
- CAPTURE: at the end edge, hi/lo <= selected engine outputs; done=1 for one cycle; busy=0; state=IDLE.
- Timing: busy is high for exactly LAT+2 cycles (DIV: 34, MULT: 35).
- done and the new hi/lo appear together, one cycle after CAPTURE.
- busy drops on the same edge, so a back-to-back request can be accepted in the done cycle.
- flush (highest priority, any state):
  - state=IDLE, busy=0, hi/lo unchanged, no done.
  - If the state was START/WAIT/CAPTURE, eng_clr=1 for one cycle.
  - flush together with op_valid in IDLE drops the request.
- op_valid while busy=1 is ignored; the control unit holds the request until busy=0.
- eng_a/eng_b never change while busy=1.
- Engines are signed; the controller copies results without interpretation.

Decomposition:
- Shared package hilo_pkg:
  - op_code constants (OP_NOP, OP_MULT, OP_DIV, OP_MTHI, OP_MTLO).
  - state encoding.
  - default DIV_LAT and MULT_LAT.
- No sub-module; the latency counter stays inline.

Test Plan:
- Reset 0 then 1; DIV with op_a=100, op_b=7 → eng_div_start is one cycle after accept; busy is 34 cycles; done pulse with hi=2, lo=14.
- MULT with op_a=0x00010000, op_b=0x00010000 (behavioural engine model, 33-cycle latency) → busy 35 cycles; hi=0x00000001, lo=0x00000000.
- DIV with op_a=5, op_b=0 → div_zero_exc one-cycle pulse; no eng_div_start; busy=0; hi/lo keep prior values.
- MTHI with op_a=0xDEADBEEF → hi=0xDEADBEEF the next cycle with done pulse; a following MTLO with op_a=0x12345678 → lo=0x12345678.
- DIV 100/7, then flush at WAIT cycle 10 → eng_clr pulse; busy=0 next cycle; no done; hi/lo unchanged. Then DIV 9/2 → hi=1, lo=4.
- DIV 100/7, then reset low at WAIT cycle 5 → all outputs 0 immediately (asynchronously); after release, no spurious done or capture.
